// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the multi-cycle RISC datapath
//
// Purpose:
//   Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB over a shared
//   instruction/data memory with wait states. Drives datapath mux selects and
//   write enables, resolves branches from func3 and the ALU flags, and traps
//   illegal opcodes or memory timeouts in a sticky FAULT state.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   opcode, func3         instruction fields from the instruction register
//   Zero_Flag, Sign_Flag  ALU flags for the current cycle
//   mem_ready             memory completes the pending access this cycle
//   mem_req, MemWrite     memory request / store qualifier, held until mem_ready
//   AdrSrc                memory address select (0 PC, 1 ALUOut)
//   IRWrite, PCWrite      instruction register / program counter load enables
//   RegWrite              register file write enable
//   ALUSrcA, ALUSrcB      ALU operand selects
//   ResultSrc, ImmSrc     result bus select, immediate format select
//   ALUOp                 operation class for the ALU decoder
//   instr_retired         one-cycle pulse when an instruction completes
//   fault                 high while parked in FAULT

module multicycle_controller #(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       Zero_Flag,
  input  logic       Sign_Flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUOp,
  output logic       instr_retired,
  output logic       fault
);

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [TIMEOUT_W-1:0] WAIT_LIMIT = TIMEOUT_W'(TIMEOUT_MAX);
  localparam logic [TIMEOUT_W-1:0] WAIT_SAT   = '1;

  typedef enum logic [3:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALUWB,
    S_BRANCH,
    S_FAULT
  } state_t;

  state_t                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                   mem_state;
  logic                   timed_out;
  logic                   branch_taken;

  // States that hold mem_req high and are subject to the wait timeout.
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);

  // mem_ready is checked separately at the call sites, so ready on the
  // limit cycle still completes the access.
  assign timed_out = (wait_cnt_q == WAIT_LIMIT);

  // Unsupported func3 encodings resolve as not taken rather than faulting.
  always_comb begin
    branch_taken = 1'b0;
    case (func3)
      3'b000:  branch_taken = Zero_Flag;
      3'b001:  branch_taken = !Zero_Flag;
      3'b100:  branch_taken = Sign_Flag;
      3'b101:  branch_taken = !Sign_Flag;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)      state_d = S_DECODE;
        else if (timed_out) state_d = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BRANCH:    state_d = S_BRANCH;
          default:      state_d = S_FAULT;
        endcase
      end
      // IR is only reloaded in FETCH, so opcode is still the lw/sw seen in DECODE.
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready)      state_d = S_MEMWB;
        else if (timed_out) state_d = S_FAULT;
      end
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready)      state_d = S_FETCH;
        else if (timed_out) state_d = S_FAULT;
      end
      S_EXEC_R:  state_d = S_ALUWB;
      S_EXEC_I:  state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_FAULT;
    endcase
  end

  // Wait counter: any state change clears it, which covers every entry into
  // a memory state; it saturates instead of wrapping.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_state && !mem_ready && (wait_cnt_q != WAIT_SAT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RST;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Moore output decode; IRWrite/PCWrite/instr_retired in the memory states
  // are additionally qualified by mem_ready (the completing cycle).
  always_comb begin
    mem_req       = 1'b0;
    MemWrite      = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ResultSrc     = 2'b00;
    ImmSrc        = 2'b00;
    ALUOp         = 2'b00;
    instr_retired = 1'b0;
    fault         = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 is computed directly on the ALU and written through ResultSrc=10.
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        // Speculatively compute OldPC + B-imm into ALUOut for a possible branch.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_SW) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req       = 1'b1;
        MemWrite      = 1'b1;
        AdrSrc        = 1'b1;
        instr_retired = mem_ready;
      end
      S_EXEC_R: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXEC_I: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      S_BRANCH: begin
        // ALU compares rs1/rs2 for the flags; ALUOut still holds the target.
        ALUSrcA       = 2'b10;
        ALUOp         = 2'b01;
        PCWrite       = branch_taken;
        instr_retired = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed checks of multicycle_controller outputs per cycle

module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       Zero_Flag;
  logic       Sign_Flag;
  logic       mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUOp;
  logic       instr_retired, fault;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.TIMEOUT_W(8), .TIMEOUT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3),
    .Zero_Flag(Zero_Flag), .Sign_Flag(Sign_Flag), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUOp(ALUOp),
    .instr_retired(instr_retired), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {mem_req,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUOp,instr_retired,fault}
  logic [17:0] outs;
  assign outs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                 ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUOp, instr_retired, fault};

  localparam logic [17:0] O_RST        = 18'b0;
  localparam logic [17:0] O_FETCH_WAIT = {6'b100000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] O_FETCH_RDY  = {6'b100110, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] O_DECODE     = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] O_MEMADR_LW  = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] O_MEMADR_SW  = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] O_MEMREAD    = {6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] O_MEMWB      = {6'b000001, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] O_MEMWR_WAIT = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] O_MEMWR_RDY  = {6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] O_EXEC_R     = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0};
  localparam logic [17:0] O_EXEC_I     = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0};
  localparam logic [17:0] O_ALUWB      = {6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] O_BR_NT      = {6'b000000, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0};
  localparam logic [17:0] O_BR_T       = {6'b000010, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0};
  localparam logic [17:0] O_FAULT      = 18'b1;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

  // Settle, then compare the output bundle without advancing the clock.
  task automatic now(input string tag, input logic [17:0] exp);
    #1;
    checks++;
    assert (outs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, outs, exp);
    end
  endtask

  // Check this cycle, then move to 1 time unit after the next rising edge.
  task automatic cyc(input string tag, input logic [17:0] exp);
    now(tag, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = OP_R; func3 = 3'b000;
    Zero_Flag = 1'b0; Sign_Flag = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_held", O_RST);
    rst_n = 1'b1;
    cyc("rst_release", O_RST);

    // R-type, zero wait: FETCH, DECODE, EXEC_R, ALUWB
    cyc("r_fetch", O_FETCH_RDY);
    cyc("r_decode", O_DECODE);
    cyc("r_exec", O_EXEC_R);
    cyc("r_aluwb", O_ALUWB);

    // I-type
    opcode = OP_I;
    cyc("i_fetch", O_FETCH_RDY);
    cyc("i_decode", O_DECODE);
    cyc("i_exec", O_EXEC_I);
    cyc("i_aluwb", O_ALUWB);

    // lw with 3 wait cycles in MEMREAD: 8 cycles total
    opcode = OP_LW;
    cyc("lw_fetch", O_FETCH_RDY);
    mem_ready = 1'b0;
    cyc("lw_decode", O_DECODE);
    cyc("lw_memadr", O_MEMADR_LW);
    cyc("lw_memread_w1", O_MEMREAD);
    cyc("lw_memread_w2", O_MEMREAD);
    cyc("lw_memread_w3", O_MEMREAD);
    mem_ready = 1'b1;
    cyc("lw_memread_rdy", O_MEMREAD);
    cyc("lw_memwb", O_MEMWB);

    // sw with one wait cycle; retire on the ready cycle
    opcode = OP_SW;
    cyc("sw_fetch", O_FETCH_RDY);
    cyc("sw_decode", O_DECODE);
    cyc("sw_memadr", O_MEMADR_SW);
    mem_ready = 1'b0;
    cyc("sw_memwrite_w", O_MEMWR_WAIT);
    mem_ready = 1'b1;
    cyc("sw_memwrite_rdy", O_MEMWR_RDY);

    // Branches
    opcode = OP_BR; func3 = 3'b000; Zero_Flag = 1'b1;
    cyc("beq_t_fetch", O_FETCH_RDY);
    cyc("beq_t_decode", O_DECODE);
    cyc("beq_taken", O_BR_T);
    Zero_Flag = 1'b0;
    cyc("beq_nt_fetch", O_FETCH_RDY);
    cyc("beq_nt_decode", O_DECODE);
    cyc("beq_not_taken", O_BR_NT);
    func3 = 3'b101; Sign_Flag = 1'b0;
    cyc("bge_fetch", O_FETCH_RDY);
    cyc("bge_decode", O_DECODE);
    cyc("bge_taken", O_BR_T);
    func3 = 3'b001; Zero_Flag = 1'b1;
    cyc("bne_fetch", O_FETCH_RDY);
    cyc("bne_decode", O_DECODE);
    cyc("bne_not_taken", O_BR_NT);
    func3 = 3'b100; Sign_Flag = 1'b1;
    cyc("blt_fetch", O_FETCH_RDY);
    cyc("blt_decode", O_DECODE);
    cyc("blt_taken", O_BR_T);
    func3 = 3'b010; Zero_Flag = 1'b1; Sign_Flag = 1'b1;
    cyc("f010_fetch", O_FETCH_RDY);
    cyc("f010_decode", O_DECODE);
    cyc("f010_not_taken", O_BR_NT);

    // Illegal opcode -> sticky FAULT, mem_ready toggling is ignored
    opcode = OP_BAD;
    cyc("bad_fetch", O_FETCH_RDY);
    cyc("bad_decode", O_DECODE);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      cyc("fault_hold", O_FAULT);
    end
    rst_n = 1'b0;
    now("fault_async_reset", O_RST);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("fault_rst_release", O_RST);

    // Timeout: limit 4, mem_ready never arrives -> FAULT after 5 FETCH cycles
    mem_ready = 1'b0; opcode = OP_R;
    for (int i = 0; i < 5; i++) cyc("to_fetch_wait", O_FETCH_WAIT);
    cyc("to_fault", O_FAULT);
    rst_n = 1'b0;
    cyc("to_reset", O_RST);
    rst_n = 1'b1;
    cyc("to_rst_release", O_RST);

    // Ready on the 5th FETCH cycle wins over the timeout
    for (int i = 0; i < 4; i++) cyc("edge_fetch_wait", O_FETCH_WAIT);
    mem_ready = 1'b1;
    cyc("edge_fetch_rdy", O_FETCH_RDY);
    cyc("edge_decode", O_DECODE);
    cyc("edge_exec", O_EXEC_R);
    cyc("edge_aluwb", O_ALUWB);

    // Reset asserted mid-MEMREAD drops mem_req immediately
    opcode = OP_LW;
    cyc("mr_fetch", O_FETCH_RDY);
    cyc("mr_decode", O_DECODE);
    cyc("mr_memadr", O_MEMADR_LW);
    mem_ready = 1'b0;
    now("mr_memread", O_MEMREAD);
    rst_n = 1'b0;
    now("mr_async_reset", O_RST);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    cyc("mr_rst_release", O_RST);
    cyc("mr_refetch", O_FETCH_RDY);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
